// File: rtl/adc_spi_responder_if.sv
// SPI pin bundle between the polling master and the ADC responder model.
interface adc_spi_responder_if;
  logic sclk;
  logic cs_n;
  logic din;
  logic dout;
  logic dout_oe;

  modport master (output sclk, output cs_n, output din, input dout, input dout_oe);
  modport slave  (input sclk, input cs_n, input din, output dout, output dout_oe);
endinterface

// File: rtl/adc_spi_responder.sv
// SPI responder model of the 8-channel 12-bit serial ADC; the address received
// in one frame selects the channel returned in the following frame.
module adc_spi_responder #(
  parameter int DATA_W      = 12,
  parameter int FRAME_BITS  = 16,
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  adc_spi_responder_if.slave     spi,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  output logic                   busy,
  output logic [2:0]             addr_rcvd,
  output logic                   frame_done,
  output logic                   frame_err
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(FRAME_BITS + 1);
  localparam logic [CW-1:0] ADDR_FIRST = CW'(2);
  localparam logic [CW-1:0] ADDR_LAST  = CW'(4);

  typedef enum logic [1:0] {IDLE, ACTIVE, OVERRUN} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, din_sync;
  logic                    sclk_d, cs_d;
  logic                    sclk_s, cs_s, din_s;
  logic                    sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [CW-1:0]           rise_cnt;
  logic [2:0]              addr_sh;
  logic [2:0]              sel;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [DATA_W-1:0]       ch_sel;
  logic [FRAME_BITS-1:0]   load_word;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign din_s     = din_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  assign ch_sel    = ch_data[sel*DATA_W +: DATA_W];
  assign load_word = {{(FRAME_BITS-DATA_W){1'b0}}, ch_sel};

  // cs_n chain resets to "asserted" so a frame already running on the bus
  // when reset releases never looks like a fresh cs_n fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      cs_sync   <= '0;
      din_sync  <= '0;
      sclk_d    <= 1'b1;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], spi.din};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      spi.dout    <= 1'b0;
      spi.dout_oe <= 1'b0;
      busy        <= 1'b0;
      addr_rcvd   <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      sel         <= '0;
      addr_sh     <= '0;
      rise_cnt    <= '0;
      shift_q     <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          spi.dout    <= 1'b0;
          spi.dout_oe <= 1'b0;
          if (cs_fall) begin
            shift_q     <= load_word;
            spi.dout    <= load_word[FRAME_BITS-1];
            spi.dout_oe <= 1'b1;
            busy        <= 1'b1;
            rise_cnt    <= '0;
            state       <= ACTIVE;
          end
        end
        ACTIVE, OVERRUN: begin
          if (cs_rise) begin
            state       <= IDLE;
            spi.dout    <= 1'b0;
            spi.dout_oe <= 1'b0;
            busy        <= 1'b0;
            if (state == ACTIVE && rise_cnt == CNT_LAST) begin
              addr_rcvd  <= addr_sh;
              sel        <= addr_sh;
              frame_done <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else if (state == ACTIVE) begin
            if (sclk_rise) begin
              if (rise_cnt >= ADDR_FIRST && rise_cnt <= ADDR_LAST)
                addr_sh <= {addr_sh[1:0], din_s};
              if (rise_cnt == CNT_LAST) begin
                rise_cnt <= CNT_MAX;
                spi.dout <= 1'b0;
                state    <= OVERRUN;
              end else begin
                rise_cnt <= rise_cnt + 1'b1;
              end
            end else if (sclk_fall && rise_cnt != '0) begin
              shift_q  <= {shift_q[FRAME_BITS-2:0], 1'b0};
              spi.dout <= shift_q[FRAME_BITS-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: frames driven at the pin level with
// hand-computed dout words, pulse counts and address capture.
module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] ch_data;
  logic        busy;
  logic [2:0]  addr_rcvd;
  logic        frame_done;
  logic        frame_err;

  int n_cmp = 0;
  int n_mis = 0;
  int n_done = 0;
  int n_errp = 0;
  int d0, e0;
  logic [31:0] cap;

  adc_spi_responder_if spi_if ();

  adc_spi_responder #(
    .DATA_W(12), .FRAME_BITS(16), .N_CH(8), .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi        (spi_if.slave),
    .ch_data    (ch_data),
    .busy       (busy),
    .addr_rcvd  (addr_rcvd),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done === 1'b1) n_done <= n_done + 1;
    if (frame_err === 1'b1) n_errp <= n_errp + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // evt 1: ch0 overwritten with 12'hFFF at rise evt_at; evt 2: reset pulse at rise evt_at
  task automatic run_frame(input logic [2:0] addr, input int nrises, input int evt,
                           input int evt_at, input logic [15:0] exp_lat, input bit chk_lat);
    cap = '0;
    spi_if.cs_n = 1'b0;
    wait_clks(6);
    for (int i = 0; i < nrises; i++) begin
      spi_if.sclk = 1'b0;
      spi_if.din  = (i >= 2 && i <= 4) ? addr[4-i] : 1'b1;
      if (chk_lat && i >= 1) begin
        @(posedge clk); @(posedge clk); #1;
        chk($sformatf("lat_hold_%0d", i), {31'd0, spi_if.dout}, {31'd0, exp_lat[16-i]});
        @(posedge clk); #1;
        chk($sformatf("lat_new_%0d", i), {31'd0, spi_if.dout}, {31'd0, exp_lat[15-i]});
        wait_clks(4);
      end else begin
        wait_clks(6);
      end
      if (i == 0) chk("oe_busy_active", {30'd0, spi_if.dout_oe, busy}, 32'd3);
      cap = {cap[30:0], spi_if.dout};
      spi_if.sclk = 1'b1;
      if (evt == 1 && i == evt_at) ch_data[11:0] = 12'hFFF;
      if (evt == 2 && i == evt_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_dout", {31'd0, spi_if.dout}, 32'd0);
        chk("rst_mid_oe", {31'd0, spi_if.dout_oe}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_addr", {29'd0, addr_rcvd}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        wait_clks(5);
      end else begin
        wait_clks(6);
      end
    end
    wait_clks(3);
    spi_if.cs_n = 1'b1;
    spi_if.din  = 1'b0;
    wait_clks(8);
  endtask

  initial begin
    rst_n = 1'b0;
    spi_if.sclk = 1'b1;
    spi_if.cs_n = 1'b1;
    spi_if.din  = 1'b0;
    ch_data = '0;
    ch_data[11:0] = 12'hA5C;
    wait_clks(3);
    chk("rst_dout", {31'd0, spi_if.dout}, 32'd0);
    chk("rst_oe", {31'd0, spi_if.dout_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {29'd0, addr_rcvd}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    wait_clks(4);

    // frame 0: ch0 returned, with dout latency checked on every shifting fall
    d0 = n_done; e0 = n_errp;
    run_frame(3'd0, 16, 0, 0, 16'h0A5C, 1'b1);
    chk("f0_data", {16'd0, cap[15:0]}, 32'h0A5C);
    chk("f0_done", n_done - d0, 1);
    chk("f0_err", n_errp - e0, 0);
    chk("f0_addr", {29'd0, addr_rcvd}, 32'd0);

    // address 5 captured; this frame still returns ch0
    ch_data[5*12 +: 12] = 12'h3F1;
    d0 = n_done;
    run_frame(3'd5, 16, 0, 0, 16'h0, 1'b0);
    chk("f1_data", {16'd0, cap[15:0]}, 32'h0A5C);
    chk("f1_addr", {29'd0, addr_rcvd}, 32'd5);
    chk("f1_done", n_done - d0, 1);

    run_frame(3'd5, 16, 0, 0, 16'h0, 1'b0);
    chk("f2_data", {16'd0, cap[15:0]}, 32'h03F1);

    // short frame: 9 rises, address 3 must not be taken
    d0 = n_done; e0 = n_errp;
    run_frame(3'd3, 9, 0, 0, 16'h0, 1'b0);
    chk("short_bits", {23'd0, cap[8:0]}, 32'h007);
    chk("short_err", n_errp - e0, 1);
    chk("short_done", n_done - d0, 0);
    chk("short_addr", {29'd0, addr_rcvd}, 32'd5);
    chk("idle_oe", {31'd0, spi_if.dout_oe}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_frame(3'd5, 16, 0, 0, 16'h0, 1'b0);
    chk("after_short_data", {16'd0, cap[15:0]}, 32'h03F1);

    // overrun: 17 rises
    d0 = n_done; e0 = n_errp;
    run_frame(3'd5, 17, 0, 0, 16'h0, 1'b0);
    chk("ovr_data", {16'd0, cap[16:1]}, 32'h03F1);
    chk("ovr_tail", {31'd0, cap[0]}, 32'd0);
    chk("ovr_err", n_errp - e0, 1);
    chk("ovr_done", n_done - d0, 0);
    chk("ovr_addr", {29'd0, addr_rcvd}, 32'd5);

    run_frame(3'd0, 16, 0, 0, 16'h0, 1'b0);
    chk("sel0_data", {16'd0, cap[15:0]}, 32'h03F1);

    // ch0 rewritten mid-frame; the loaded word must survive
    ch_data[11:0] = 12'h111;
    ch_data[2*12 +: 12] = 12'h222;
    run_frame(3'd2, 16, 1, 4, 16'h0, 1'b0);
    chk("chg_data", {16'd0, cap[15:0]}, 32'h0111);
    chk("chg_addr", {29'd0, addr_rcvd}, 32'd2);

    // reset at rise 7; rest of that frame ignored
    d0 = n_done; e0 = n_errp;
    run_frame(3'd5, 16, 2, 7, 16'h0, 1'b0);
    chk("rstf_done", n_done - d0, 0);
    chk("rstf_err", n_errp - e0, 0);
    chk("rstf_addr", {29'd0, addr_rcvd}, 32'd0);
    chk("rstf_busy", {31'd0, busy}, 32'd0);

    d0 = n_done;
    run_frame(3'd0, 16, 0, 0, 16'h0, 1'b0);
    chk("post_rst_data", {16'd0, cap[15:0]}, 32'h0FFF);
    chk("post_rst_done", n_done - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
